mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer that shares the single-port instruction/data RAM between the core's instruction-fetch path and its load/store path. Each requester uses a req/ready handshake. The arbiter picks one requester, drives the RAM address, write and data lines for a fixed access window, and honours the RAM's `busy` stall. It then returns registered read data with a one-cycle `ready` pulse. It sits between the single-cycle core's fetch/LSU logic and the RAM.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_picker.sv | 31 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
package mem_arb_pkg;

    localparam int ARB_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection between fetch and load/store requesters.
// Define MEM_ARB_FIXED_PRIO_EN for fixed D-over-I priority; default is round-robin.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
`ifndef MEM_ARB_FIXED_PRIO_EN
    input  arb_owner_t last_grant,
`endif
    output logic       grant_valid,
    output arb_owner_t grant
);

    // NOTE: every output gets a default first so no path through the block leaves a latch.
    always_comb begin
        grant_valid = i_req | d_req;
        grant       = OWN_I;
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (d_req) grant = OWN_D;
`else
        if (i_req && d_req) begin
            // On a tie, whoever was not served last goes next.
            grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            grant = OWN_D;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the shared single-port RAM.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed D priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy
);

    arb_state_t             state, state_nxt;
    arb_owner_t             owner;
    logic [ARB_CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]      lat_addr;
    logic                   lat_we;
    logic [DATA_W-1:0]      lat_wdata;
    logic                   grant_valid;
    arb_owner_t             grant;
    logic                   final_cycle;

`ifndef MEM_ARB_FIXED_PRIO_EN
    arb_owner_t             last_grant;
`endif

    mem_arb_picker u_picker (
        .i_req       (i_req),
        .d_req       (d_req),
`ifndef MEM_ARB_FIXED_PRIO_EN
        .last_grant  (last_grant),
`endif
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign final_cycle = (state == ACCESS) && (cnt == '0) && !mem_busy;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = ACCESS;
            ACCESS:  if (final_cycle) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: the rdata registers are architecturally visible, so they are reset like any other output.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_I;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant <= OWN_D;
`endif
        end else begin
            case (state)
                IDLE: if (grant_valid) begin
                    owner     <= grant;
                    // Word-align here so the RAM never sees byte-offset bits.
                    lat_addr  <= ((grant == OWN_D) ? d_addr : i_addr) & ~ADDR_W'(3);
                    lat_we    <= (grant == OWN_D) && d_we;
                    lat_wdata <= (grant == OWN_D) ? d_wdata : '0;
                    cnt       <= ARB_CNT_W'(WAIT_CYCLES);
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_grant <= grant;
`endif
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (final_cycle && !lat_we) begin
                        if (owner == OWN_I) i_rdata <= mem_rdata;
                        else                d_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated by rst so a reset landing on the final cycle cannot write.
    assign mem_addr  = (!rst && state == ACCESS) ? lat_addr  : '0;
    assign mem_wdata = (!rst && state == ACCESS) ? lat_wdata : '0;
    assign mem_we    = !rst && final_cycle && lat_we;
    assign i_ready   = !rst && (state == DONE) && (owner == OWN_I);
    assign d_ready   = !rst && (state == DONE) && (owner == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (WAIT_CYCLES = 2) with a behavioural RAM.
module tb_mem_arbiter;

    localparam int W = 2;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_busy = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_ready, d_ready, mem_we;

    logic [31:0] ram [0:15];

    int n_cmp = 0;
    int n_err = 0;
    int lat, we_cnt, we_at, who;
    logic [31:0] fin_addr, we_addr, we_data, prev_addr;

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[5:2]];
    always @(posedge clk) if (mem_we) ram[mem_addr[5:2]] <= mem_wdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".i_ready"},   {31'd0, i_ready}, 32'd0);
        check({tag, ".d_ready"},   {31'd0, d_ready}, 32'd0);
        check({tag, ".mem_we"},    {31'd0, mem_we},  32'd0);
        check({tag, ".mem_addr"},  mem_addr,  32'd0);
        check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        check({tag, ".i_rdata"},   i_rdata,   32'd0);
        check({tag, ".d_rdata"},   d_rdata,   32'd0);
    endtask

    // Cycle 0 is the current one (request just presented); runs until a ready, bounded to 40 cycles.
    // who: 0 = I, 1 = D, 2 = timeout, 3 = both readies at once.
    task automatic wait_ready(input int busy_from, input int busy_to);
        lat = 0; we_cnt = 0; we_at = -1; who = 2;
        fin_addr = 'x; we_addr = 'x; we_data = 'x; prev_addr = mem_addr;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            mem_busy = (k >= busy_from) && (k <= busy_to);
            #1;
            if (mem_we) begin
                we_cnt++; we_at = k; we_addr = mem_addr; we_data = mem_wdata;
            end
            if (i_ready || d_ready) begin
                lat = k; fin_addr = prev_addr;
                who = (i_ready && d_ready) ? 3 : (d_ready ? 1 : 0);
                break;
            end
            prev_addr = mem_addr;
        end
        mem_busy = 1'b0;
    endtask

    task automatic gap();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'h1000_0000 + i;
        ram[1] = 32'hDEAD_BEEF;
        ram[4] = 32'hA5A5_0004;

        // Reset state
        repeat (3) @(negedge clk);
        #1 check_zero("reset");

        // Read of word 1 by fetch port
        @(negedge clk);
        rst = 1'b0; i_req = 1'b1; i_addr = 32'h4;
        #1 check("rd.idle_addr", mem_addr, 32'h0);
        wait_ready(0, -1);
        check("rd.latency", lat, W + 2);
        check("rd.owner", who, 0);
        check("rd.we_count", we_cnt, 0);
        check("rd.addr", fin_addr, 32'h4);
        check("rd.i_rdata", i_rdata, 32'hDEAD_BEEF);
        check("rd.d_rdata", d_rdata, 32'h0);
        i_req = 1'b0;
        @(negedge clk); #1;
        check("rd.pulse_end", {31'd0, i_ready}, 32'd0);
        check("rd.hold", i_rdata, 32'hDEAD_BEEF);
        check("rd.addr_idle", mem_addr, 32'h0);

        // Write of word 2, then back-to-back readback with unaligned address
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h1234_5678;
        wait_ready(0, -1);
        check("wr.latency", lat, W + 2);
        check("wr.owner", who, 1);
        check("wr.we_count", we_cnt, 1);
        check("wr.we_cycle", we_at, W + 1);
        check("wr.we_addr", we_addr, 32'h8);
        check("wr.we_data", we_data, 32'h1234_5678);
        check("wr.ram", ram[2], 32'h1234_5678);
        check("wr.d_rdata", d_rdata, 32'h0);
        d_we = 1'b0; d_addr = 32'hB;
        wait_ready(0, -1);
        check("rb.latency", lat, W + 3);
        check("rb.owner", who, 1);
        check("rb.addr_align", fin_addr, 32'h8);
        check("rb.d_rdata", d_rdata, 32'h1234_5678);
        check("rb.i_rdata", i_rdata, 32'hDEAD_BEEF);
        gap();

        // Busy stall of five cycles while the counter is zero
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h14; d_wdata = 32'h0BAD_F00D;
        wait_ready(W + 1, W + 5);
        check("busy.latency", lat, W + 2 + 5);
        check("busy.we_count", we_cnt, 1);
        check("busy.we_cycle", we_at, W + 1 + 5);
        check("busy.ram", ram[5], 32'h0BAD_F00D);
        gap();

        // Reset landing on the final cycle of a write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'hC; d_wdata = 32'hCAFE_F00D;
        repeat (W + 1) @(negedge clk);
        rst = 1'b1;
        #1 check("rst.no_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0; d_we = 1'b0; d_addr = 32'h10; i_req = 1'b1; i_addr = 32'h4;
        #1 check_zero("rst.after");
        check("rst.ram", ram[3], 32'h1000_0003);

        // Continuous tie after reset
        wait_ready(0, -1);
        check("tie1.latency", lat, W + 2);
        check("tie1.owner", who, FIXED ? 1 : 0);
        check("tie1.i_rdata", i_rdata, FIXED ? 32'h0 : 32'hDEAD_BEEF);
        check("tie1.d_rdata", d_rdata, FIXED ? 32'hA5A5_0004 : 32'h0);
        for (int g = 2; g <= 4; g++) begin
            wait_ready(0, -1);
            check($sformatf("tie%0d.latency", g), lat, W + 3);
            check($sformatf("tie%0d.owner", g), who, FIXED ? 1 : (g % 2 == 0 ? 1 : 0));
        end
        check("tie.i_rdata", i_rdata, FIXED ? 32'h0 : 32'hDEAD_BEEF);
        check("tie.d_rdata", d_rdata, 32'hA5A5_0004);
        gap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
